// File: rtl/fft_pkg.sv
// Shared types and address generation for the radix-2 DIT FFT engine.
// Used by the butterfly sequencer and the datapath alike.
package fft_pkg;

    localparam int N_LOG2 = 7;
    localparam int N      = 1 << N_LOG2;

    typedef logic [N_LOG2-1:0] addr_t;
    typedef logic [N_LOG2-2:0] tw_t;
    typedef logic [N_LOG2-2:0] jdx_t;
    typedef logic [2:0]        stage_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        addr_t a;
        addr_t b;
        tw_t   tw;
    } bfly_t;

    // Butterfly j of stage s: insert a zero bit at position s of j.
    function automatic bfly_t bfly_addr(
        input stage_t s,
        input jdx_t   j
    );
        addr_t jx;
        addr_t span;
        addr_t pos;
        addr_t grp;
        addr_t a;
        bfly_t r;
        jx     = addr_t'(j);
        span   = addr_t'(1) << s;
        pos    = jx & (span - addr_t'(1));
        grp    = jx >> s;
        a      = (grp << (s + 3'd1)) | pos;
        r.a    = a;
        r.b    = a + span;
        r.tw   = tw_t'(pos << (3'(N_LOG2 - 1) - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_bfly_sched_dly.sv
// Reset-clearable shift register of configurable depth and width.
// A depth of zero degenerates to a wire.
module fft_dly_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_thru
        assign q_o = d_i;
    end else begin : g_sr
        logic [W-1:0] sr_q [DEPTH];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    sr_q[i] <= '0;
                end
            end else begin
                sr_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 FFT butterfly sequencer with write-back alignment.
// Optional FFT_SCALE_EN adds the per-stage Scale output.
module fft_bfly_sched
    import fft_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 2
`ifdef FFT_SCALE_EN
    ,
    parameter logic [N_LOG2-1:0] SCALE_MASK = '0
`endif
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              RdEn,
    output logic [N_LOG2-1:0] RdAddrA,
    output logic [N_LOG2-1:0] RdAddrB,
    output logic [N_LOG2-2:0] TwIdx,
    output logic              BfValid,
    output logic              WrEn,
    output logic [N_LOG2-1:0] WrAddrA,
    output logic [N_LOG2-1:0] WrAddrB,
`ifdef FFT_SCALE_EN
    output logic              Scale,
`endif
    output logic [2:0]        Stage
);

    localparam int L = RD_LAT + BF_LAT;
    localparam logic [7:0] GAP_LAST =
        (L > 0) ? 8'(L - 1) : 8'd0;
    localparam stage_t S_LAST = 3'(N_LOG2 - 1);
    localparam jdx_t   J_LAST = '1;
    localparam int     WW     = 1 + 2 * N_LOG2;

    state_t     state_q;
    stage_t     s_q;
    jdx_t       j_q;
    logic [7:0] gap_q;
    logic       rd_en_q;
    bfly_t      rd_q;
    logic       busy_q;
    logic       done_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            gap_q   <= '0;
            rd_en_q <= 1'b0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    rd_en_q <= 1'b0;
                    if (Start) begin
                        state_q <= RUN;
                        s_q     <= '0;
                        j_q     <= '0;
                        rd_en_q <= 1'b1;
                        rd_q    <= bfly_addr('0, '0);
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (j_q != J_LAST) begin
                        j_q  <= jdx_t'(j_q + 1'b1);
                        rd_q <= bfly_addr(s_q,
                                    jdx_t'(j_q + 1'b1));
                    end else if (s_q != S_LAST) begin
                        if (L == 0) begin
                            s_q  <= stage_t'(s_q + 3'd1);
                            j_q  <= '0;
                            rd_q <= bfly_addr(
                                stage_t'(s_q + 3'd1), '0);
                        end else begin
                            state_q <= GAP;
                            gap_q   <= '0;
                            rd_en_q <= 1'b0;
                        end
                    end else begin
                        rd_en_q <= 1'b0;
                        gap_q   <= '0;
                        if (L == 0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                // Hold off reads until the last write of the stage lands.
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= RUN;
                        s_q     <= stage_t'(s_q + 3'd1);
                        j_q     <= '0;
                        rd_en_q <= 1'b1;
                        rd_q    <= bfly_addr(
                            stage_t'(s_q + 3'd1), '0);
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FFT_SCALE_EN
    logic [1:0] bf_d;
    logic [1:0] bf_q;

    assign bf_d = {rd_en_q, rd_en_q & SCALE_MASK[s_q]};
    assign BfValid = bf_q[1];
    assign Scale   = bf_q[0];

    fft_dly_line #(.DEPTH(RD_LAT), .W(2)) u_bf_dly (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .d_i    (bf_d),
        .q_o    (bf_q)
    );
`else
    fft_dly_line #(.DEPTH(RD_LAT), .W(1)) u_bf_dly (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .d_i    (rd_en_q),
        .q_o    (BfValid)
    );
`endif

    logic [WW-1:0] wr_d;
    logic [WW-1:0] wr_q;

    assign wr_d = {rd_en_q, rd_q.a, rd_q.b};

    fft_dly_line #(.DEPTH(L), .W(WW)) u_wr_dly (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .d_i    (wr_d),
        .q_o    (wr_q)
    );

    assign WrEn    = wr_q[WW-1];
    assign WrAddrA = wr_q[2*N_LOG2-1:N_LOG2];
    assign WrAddrB = wr_q[N_LOG2-1:0];

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign RdEn    = rd_en_q;
    assign RdAddrA = rd_q.a;
    assign RdAddrB = rd_q.b;
    assign TwIdx   = rd_q.tw;
    assign Stage   = s_q;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench for fft_bfly_sched: vector table plus cycle model.
// Build with FFT_SCALE_EN to also check the Scale output.
module tb_fft_bfly_sched;
    import fft_pkg::*;

    localparam logic [6:0] MASK = 7'b1010101;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       Busy, Done, RdEn, BfValid, WrEn;
    logic [6:0] RdAddrA, RdAddrB, WrAddrA, WrAddrB;
    logic [5:0] TwIdx;
    logic [2:0] Stage;
`ifdef FFT_SCALE_EN
    logic       Scale;
`endif

    always #5 Clk = ~Clk;

`ifdef FFT_SCALE_EN
    fft_bfly_sched #(
        .RD_LAT(1), .BF_LAT(2), .SCALE_MASK(MASK)
    ) dut (
`else
    fft_bfly_sched #(.RD_LAT(1), .BF_LAT(2)) dut (
`endif
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .Busy(Busy), .Done(Done), .RdEn(RdEn),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
        .TwIdx(TwIdx), .BfValid(BfValid), .WrEn(WrEn),
        .WrAddrA(WrAddrA), .WrAddrB(WrAddrB),
`ifdef FFT_SCALE_EN
        .Scale(Scale),
`endif
        .Stage(Stage)
    );

    typedef struct {
        int c;
        int rd; int a; int b; int tw; int st;
        int wr; int wa; int wb;
        int busy; int done;
    } tv_t;

    tv_t tv [15];
    int n_cmp = 0;
    int n_bad = 0;
    int n_rd  = 0;
    int n_wr  = 0;

    task automatic chk(input string nm, input int c,
                       input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d",
                     nm, c, act, exp);
        end
    endtask

    // Spec cycle model: 64 issues, 3 gap cycles per stage.
    task automatic mdl(input int cc, output int rd,
                       output int s, output int j,
                       output int busy, output int done);
        int t;
        t    = cc - 1;
        busy = (cc >= 1 && cc <= 470) ? 1 : 0;
        done = (cc == 470) ? 1 : 0;
        rd   = (cc >= 1 && t < 466 && (t % 67) < 64) ? 1 : 0;
        s    = (t < 0) ? 0 : t / 67;
        if (s > 6) s = 6;
        j    = (t < 0) ? 0 : t % 67;
    endtask

    function automatic int ea(input int s, input int j);
        return j + ((j >> s) << s);
    endfunction

    function automatic int etw(input int s, input int j);
        return (j & ((1 << s) - 1)) * (64 >> s);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_cycle(input int c, input int cc,
                               input bit use_tbl);
        int rd, s, j, bz, dn;
        int wrd, ws, wj, d0, d1;
        int brd, bs, bj;
        logic [6:0] mv;
        mv = MASK;
        mdl(cc, rd, s, j, bz, dn);
        chk("RdEn", c, int'(RdEn), rd);
        if (rd != 0) begin
            chk("RdAddrA", c, int'(RdAddrA), ea(s, j));
            chk("RdAddrB", c, int'(RdAddrB),
                ea(s, j) + (1 << s));
            chk("TwIdx", c, int'(TwIdx), etw(s, j));
        end
        if (bz != 0) chk("Stage", c, int'(Stage), s);
        chk("Busy", c, int'(Busy), bz);
        chk("Done", c, int'(Done), dn);
        mdl(cc - 3, wrd, ws, wj, d0, d1);
        chk("WrEn", c, int'(WrEn), wrd);
        if (wrd != 0) begin
            chk("WrAddrA", c, int'(WrAddrA), ea(ws, wj));
            chk("WrAddrB", c, int'(WrAddrB),
                ea(ws, wj) + (1 << ws));
        end
        mdl(cc - 1, brd, bs, bj, d0, d1);
        chk("BfValid", c, int'(BfValid), brd);
`ifdef FFT_SCALE_EN
        chk("Scale", c, int'(Scale),
            (brd != 0) ? int'(mv[bs]) : 0);
`endif
        if (RdEn) n_rd++;
        if (WrEn) n_wr++;
        if (use_tbl) begin
            for (int k = 0; k < 15; k++) begin
                if (tv[k].c == c) begin
                    chk("T.rd", c, int'(RdEn), tv[k].rd);
                    if (tv[k].a >= 0)
                        chk("T.a", c, int'(RdAddrA), tv[k].a);
                    if (tv[k].b >= 0)
                        chk("T.b", c, int'(RdAddrB), tv[k].b);
                    if (tv[k].tw >= 0)
                        chk("T.tw", c, int'(TwIdx), tv[k].tw);
                    chk("T.st", c, int'(Stage), tv[k].st);
                    chk("T.wr", c, int'(WrEn), tv[k].wr);
                    if (tv[k].wa >= 0)
                        chk("T.wa", c, int'(WrAddrA), tv[k].wa);
                    if (tv[k].wb >= 0)
                        chk("T.wb", c, int'(WrAddrB), tv[k].wb);
                    chk("T.busy", c, int'(Busy), tv[k].busy);
                    chk("T.done", c, int'(Done), tv[k].done);
                end
            end
        end
    endtask

    // Start at edge 0, then check cycles 1..ncyc.
    task automatic run_check(input int ncyc, input bit hold,
                             input bit use_tbl);
        int cc;
        n_rd = 0;
        n_wr = 0;
        Start = 1'b1;
        tick();
        if (!hold) Start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            cc = hold ? ((c - 1) % 471) + 1 : c;
            check_cycle(c, cc, use_tbl);
            if (!hold) Start = (c == 100 || c == 470);
            tick();
        end
        Start = 1'b0;
    endtask

    task automatic chk_quiet(input string nm, input int c);
        chk({nm, ".RdEn"}, c, int'(RdEn), 0);
        chk({nm, ".WrEn"}, c, int'(WrEn), 0);
        chk({nm, ".Done"}, c, int'(Done), 0);
        chk({nm, ".Busy"}, c, int'(Busy), 0);
        chk({nm, ".BfV"}, c, int'(BfValid), 0);
    endtask

    initial begin
        tv[0]  = '{1,   1, 0, 1, 0, 0,  0, -1, -1,  1, 0};
        tv[1]  = '{2,   1, 2, 3, 0, 0,  0, -1, -1,  1, 0};
        tv[2]  = '{4,   1, 6, 7, 0, 0,  1, 0, 1,    1, 0};
        tv[3]  = '{64,  1, 126, 127, 0, 0, 1, 120, 121, 1, 0};
        tv[4]  = '{65,  0, -1, -1, -1, 0, 1, 122, 123, 1, 0};
        tv[5]  = '{67,  0, -1, -1, -1, 0, 1, 126, 127, 1, 0};
        tv[6]  = '{68,  1, 0, 2, 0, 1,  0, -1, -1,  1, 0};
        tv[7]  = '{69,  1, 1, 3, 32, 1, 0, -1, -1,  1, 0};
        tv[8]  = '{140, 1, 9, 13, 16, 2, 1, -1, -1, 1, 0};
        tv[9]  = '{466, 1, 63, 127, 63, 6, 1, -1, -1, 1, 0};
        tv[10] = '{467, 0, -1, -1, -1, 6, 1, 61, 125, 1, 0};
        tv[11] = '{469, 0, -1, -1, -1, 6, 1, 63, 127, 1, 0};
        tv[12] = '{470, 0, -1, -1, -1, 6, 0, -1, -1, 1, 1};
        tv[13] = '{471, 0, -1, -1, -1, 6, 0, -1, -1, 0, 0};
        tv[14] = '{202, 1, 0, 8, 0, 3,  0, -1, -1,  1, 0};

        Reset_n = 1'b0;
        tick();
        tick();
        chk_quiet("rst", 0);
        chk("rst.Stage", 0, int'(Stage), 0);
        chk("rst.A", 0, int'(RdAddrA), 0);
        chk("rst.WA", 0, int'(WrAddrA), 0);
        Reset_n = 1'b1;
        tick();
        tick();

        run_check(480, 1'b0, 1'b1);
        chk("rd_count", 1, n_rd, 448);
        chk("wr_count", 1, n_wr, 448);

        tick();
        run_check(560, 1'b1, 1'b0);

        repeat (480) tick();
        run_check(199, 1'b0, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_quiet("async", 200);
        chk("async.Stage", 200, int'(Stage), 0);
        tick();
        tick();
        Reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk_quiet("abort", 202 + c);
            tick();
        end

        run_check(475, 1'b0, 1'b0);
        chk("rst_rd_count", 2, n_rd, 448);
        chk("rst_wr_count", 2, n_wr, 448);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_bfly_sched.md
Name: fft_bfly_sched

Overview:
Sequencer for an in-place radix-2 DIT FFT over a shared dual-port sample memory (bit-reversed load already done by the input stage).
- Walks all log2(N) stages, issuing one butterfly per cycle: read address pair, twiddle index, butterfly-valid.
- Issues the matching write-back address pair after the fixed pipeline latency.
- Sits between the frame loader and the 128-point engine's memory, butterfly and twiddle ROM; the energy/decision stage starts on Done.

Parameters:
N_LOG2, 7, log2 of FFT size (N=128)
RD_LAT, 1, cycles from RdEn to data at butterfly input (memory and twiddle ROM identical)
BF_LAT, 2, butterfly pipeline depth, input to write data
SCALE_MASK, 7'b0, bit s=1 requests divide-by-2 in stage s (used only with FFT_SCALE_EN)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  begin transform; sampled only in IDLE
Busy  out  1  high whenever state != IDLE
Done  out  1  one-cycle pulse after last write-back
RdEn  out  1  read pair valid this cycle
RdAddrA  out  N_LOG2  upper butterfly read address
RdAddrB  out  N_LOG2  lower butterfly read address
TwIdx  out  N_LOG2-1  twiddle ROM index, aligned with RdEn
BfValid  out  1  RdEn delayed RD_LAT
WrEn  out  1  RdEn delayed L = RD_LAT+BF_LAT
WrAddrA  out  N_LOG2  RdAddrA delayed L
WrAddrB  out  N_LOG2  RdAddrB delayed L
Stage  out  3  current issue stage, 0..N_LOG2-1
Scale  out  1  FFT_SCALE_EN only; aligned with BfValid

Behaviour:
- Reset (async, Reset_n=0): state IDLE; all outputs 0; stage/butterfly counters 0; delay-line valids cleared. Reset mid-transform aborts immediately, with no Done and no further WrEn.
- States: IDLE, RUN, GAP, DRAIN, DONE.
- IDLE: Start=1 -> RUN; stage=0, j=0. Start in any other state is ignored, not queued.
- RUN: one butterfly per cycle, j=0..N/2-1.
  - span=1<<s; pos=j&(span-1); grp=j>>s.
  - RdAddrA=(grp<<(s+1))|pos; RdAddrB=RdAddrA+span; TwIdx=pos<<(N_LOG2-1-s).
  - Counter arithmetic is unsigned, widths exact, no wrap beyond N_LOG2 bits.
- After j=N/2-1:
  - If s<N_LOG2-1 -> GAP.
  - Else -> DRAIN.
- GAP: L cycles with RdEn=0 (read-after-write hazard between stages), then RUN with s+1, j=0. If L=0, RUN continues directly.
- DRAIN: L cycles, then DONE.
- DONE: Done=1 for one cycle, then IDLE. Start in DONE is ignored.
- Timing, with Start sampled high at edge 0:
  - First RdEn in cycle 1; stage s issues start at cycle 1+s*(N/2+L).
  - Last RdEn at cycle N_LOG2*N/2+(N_LOG2-1)*L; last WrEn L cycles later; Done the next cycle.
  - Defaults: RdEn 1..466 (with gaps), last WrEn 469, Done 470, Busy 1..470.
- WrEn count per transform = N_LOG2*N/2 = 448. Every WrAddr pair equals the RdAddr pair issued exactly L cycles earlier.
- Stage changes with the first issue of the new stage (during GAP it holds the completed stage).

Optional Feature:
FFT_SCALE_EN
- Defined: Scale port exists; Scale = SCALE_MASK[s] of the butterfly whose data is at the butterfly input, aligned with BfValid (0 when BfValid=0). The butterfly uses it to arithmetic-shift its outputs right by 1 to prevent overflow.
- Undefined: no Scale port, no related logic; SCALE_MASK is unused.

Decomposition:
- Package fft_pkg: N_LOG2, N, the state enum, the address and twiddle-index typedefs, and function bfly_addr(s,j) returning {A,B,tw}. The same package is shared with the datapath.
- One sub-module, fft_dly_line: parameterised depth and width, reset-clearable shift register; instantiated for the BfValid/Scale and WrEn/WrAddr alignment.

Test Plan:
1. Start pulse at cycle 0 -> RdEn cycles 1..64 with (A,B,tw) = (0,1,0),(2,3,0)...(126,127,0); BfValid from 2; WrEn 4..67 echoing the same addresses.
2. Stage 2, j=5 -> A=9, B=13, TwIdx=16; stage 6, j=63 -> A=63, B=127, TwIdx=63; GAP of exactly 3 RdEn-free cycles before each stage.
3. Full run -> exactly 448 RdEn and 448 WrEn, Done only at cycle 470, Busy 1..470, IDLE at 471.
4. Start held high continuously -> second transform's first RdEn at cycle 472; Start during Busy has no effect.
5. Reset_n low at cycle 200 -> all outputs 0 asynchronously; no WrEn or Done afterwards; a new Start after release runs a clean full transform.
6. With FFT_SCALE_EN, SCALE_MASK=7'b1010101 -> Scale=1 with BfValid in stages 0,2,4,6 only; 0 in stages 1,3,5 and whenever BfValid=0.
